// File: rtl/rx_frame_checker.sv
// UART RX frame checker: deserialises LSB-first data, checks parity and stop bit, counts errors.
// Optional error counters are compiled in with RX_ERR_CNT_EN.

// state  | meaning
// IDLE   | waiting for frame_start
// DATA   | shifting in DATA_WIDTH data bits
// PARITY | waiting for the parity bit strobe
// STOP   | waiting for the stop bit strobe
module rx_frame_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  frame_start,
  input  logic                  bit_valid,
  input  logic                  sampled_bit,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_TYP,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  frame_done,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  par_err_cnt,
  output logic [CNT_WIDTH-1:0]  stp_err_cnt
);

  localparam int BCW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BCW-1:0]        bit_cnt;
  logic                  par_acc;
  logic                  par_flag;
  logic                  cfg_par_en;
  logic [1:0]            cfg_par_typ;
  logic                  par_exp;

  always_comb begin
    par_exp = 1'b0;
    case (cfg_par_typ)
      2'b00:   par_exp = par_acc;
      2'b01:   par_exp = ~par_acc;
      2'b10:   par_exp = 1'b1;
      default: par_exp = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      par_acc     <= 1'b0;
      par_flag    <= 1'b0;
      cfg_par_en  <= 1'b0;
      cfg_par_typ <= 2'b00;
      P_DATA      <= '0;
      frame_done  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // frame_start has priority: it also aborts a frame in progress
      if (frame_start) begin
        state       <= DATA;
        cfg_par_en  <= PAR_EN;
        cfg_par_typ <= PAR_TYP;
        shift_reg   <= '0;
        bit_cnt     <= BCW'(DATA_WIDTH - 1);
        par_acc     <= 1'b0;
        par_flag    <= 1'b0;
      end else if (bit_valid) begin
        case (state)
          DATA: begin
            shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
            par_acc   <= par_acc ^ sampled_bit;
            if (bit_cnt == '0)
              state <= cfg_par_en ? PARITY : STOP;
            else
              bit_cnt <= bit_cnt - 1'b1;
          end
          PARITY: begin
            if (sampled_bit != par_exp)
              par_flag <= 1'b1;
            state <= STOP;
          end
          STOP: begin
            state      <= IDLE;
            P_DATA     <= shift_reg;
            par_err    <= cfg_par_en & par_flag;
            stp_err    <= ~sampled_bit;
            frame_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef RX_ERR_CNT_EN
  always_ff @(posedge CLK) begin
    if (!RST) begin
      par_err_cnt <= '0;
      stp_err_cnt <= '0;
    end else if (err_clr) begin
      par_err_cnt <= '0;
      stp_err_cnt <= '0;
    end else if (frame_done) begin
      if (par_err && (par_err_cnt != '1))
        par_err_cnt <= par_err_cnt + 1'b1;
      if (stp_err && (stp_err_cnt != '1))
        stp_err_cnt <= stp_err_cnt + 1'b1;
    end
  end
`else
  // Counters absent: outputs are constant zero, err_clr has no effect
  assign par_err_cnt = {CNT_WIDTH{1'b0}} & {CNT_WIDTH{err_clr}};
  assign stp_err_cnt = {CNT_WIDTH{1'b0}} & {CNT_WIDTH{err_clr}};
`endif

endmodule

// File: tb/tb_rx_frame_checker.sv
// Directed bench for rx_frame_checker: table of frames plus abort/reset/priority sequences.
// Counter expectations follow whether RX_ERR_CNT_EN is defined for the build.
module tb_rx_frame_checker;

  logic       CLK = 1'b0;
  logic       RST;
  logic       frame_start, bit_valid, sampled_bit, PAR_EN, err_clr;
  logic [1:0] PAR_TYP;
  logic [7:0] P_DATA;
  logic       frame_done, par_err, stp_err, busy;
  logic [1:0] par_err_cnt, stp_err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  rx_frame_checker #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut (
    .CLK(CLK), .RST(RST), .frame_start(frame_start), .bit_valid(bit_valid),
    .sampled_bit(sampled_bit), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .err_clr(err_clr),
    .P_DATA(P_DATA), .frame_done(frame_done), .par_err(par_err), .stp_err(stp_err),
    .busy(busy), .par_err_cnt(par_err_cnt), .stp_err_cnt(stp_err_cnt)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (frame_done) done_cnt++;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic [1:0] typ;
    logic       pb;
    logic       sb;
    int         gap;
    logic       clr;
    logic [7:0] exp_data;
    logic       exp_par;
    logic       exp_stp;
    int         exp_pc;
    int         exp_sc;
  } vec_t;

  vec_t vecs[15];

  function automatic int cnt_exp(input int v);
`ifdef RX_ERR_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic strobe(input logic b, input int gap);
    bit_valid   = 1'b1;
    sampled_bit = b;
    @(posedge CLK); #1;
    bit_valid   = 1'b0;
    repeat (gap) begin @(posedge CLK); #1; end
  endtask

  // Leaves time at 1 unit after the stop-bit edge, i.e. inside the frame_done cycle.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic [1:0] typ,
                            input logic pb, input logic sb, input int gap, input logic start_bv);
    frame_start = 1'b1;
    PAR_EN      = pe;
    PAR_TYP     = typ;
    bit_valid   = start_bv;
    sampled_bit = 1'b1;
    @(posedge CLK); #1;
    frame_start = 1'b0;
    bit_valid   = 1'b0;
    PAR_EN      = ~pe;
    PAR_TYP     = ~typ;
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < 8; i++) strobe(d[i], gap);
    if (pe) strobe(pb, gap);
    strobe(sb, 0);
  endtask

  initial begin
    RST = 1'b0; frame_start = 0; bit_valid = 0; sampled_bit = 1; PAR_EN = 0;
    PAR_TYP = 2'b00; err_clr = 0;

    vecs[0]  = '{8'hA5, 1'b0, 2'd0, 1'b0, 1'b1, 1, 1'b0, 8'hA5, 1'b0, 1'b0, 0, 0};
    vecs[1]  = '{8'h03, 1'b1, 2'd0, 1'b0, 1'b1, 1, 1'b0, 8'h03, 1'b0, 1'b0, 0, 0};
    vecs[2]  = '{8'h03, 1'b1, 2'd0, 1'b1, 1'b1, 1, 1'b0, 8'h03, 1'b1, 1'b0, 1, 0};
    vecs[3]  = '{8'h07, 1'b1, 2'd1, 1'b0, 1'b1, 1, 1'b0, 8'h07, 1'b0, 1'b0, 1, 0};
    vecs[4]  = '{8'h07, 1'b1, 2'd2, 1'b0, 1'b1, 2, 1'b0, 8'h07, 1'b1, 1'b0, 2, 0};
    vecs[5]  = '{8'h07, 1'b1, 2'd3, 1'b0, 1'b1, 0, 1'b0, 8'h07, 1'b0, 1'b0, 2, 0};
    vecs[6]  = '{8'hFF, 1'b0, 2'd0, 1'b1, 1'b0, 1, 1'b0, 8'hFF, 1'b0, 1'b1, 2, 1};
    vecs[7]  = '{8'hFF, 1'b0, 2'd0, 1'b0, 1'b0, 1, 1'b1, 8'hFF, 1'b0, 1'b1, 0, 0};
    vecs[8]  = '{8'h03, 1'b1, 2'd0, 1'b1, 1'b1, 0, 1'b0, 8'h03, 1'b1, 1'b0, 1, 0};
    vecs[9]  = '{8'h03, 1'b1, 2'd0, 1'b1, 1'b1, 0, 1'b0, 8'h03, 1'b1, 1'b0, 2, 0};
    vecs[10] = '{8'h03, 1'b1, 2'd0, 1'b1, 1'b1, 0, 1'b0, 8'h03, 1'b1, 1'b0, 3, 0};
    vecs[11] = '{8'h03, 1'b1, 2'd0, 1'b1, 1'b1, 0, 1'b0, 8'h03, 1'b1, 1'b0, 3, 0};
    vecs[12] = '{8'h03, 1'b1, 2'd0, 1'b1, 1'b1, 0, 1'b0, 8'h03, 1'b1, 1'b0, 3, 0};
    vecs[13] = '{8'h5A, 1'b1, 2'd1, 1'b1, 1'b0, 0, 1'b0, 8'h5A, 1'b0, 1'b1, 3, 1};
    vecs[14] = '{8'hC3, 1'b1, 2'd0, 1'b1, 1'b1, 1, 1'b0, 8'hC3, 1'b1, 1'b0, 3, 1};

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_p_data", P_DATA, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_par_err", par_err, 0);
    chk("rst_stp_err", stp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_par_cnt", par_err_cnt, 0);
    chk("rst_stp_cnt", stp_err_cnt, 0);
    RST = 1'b1;
    @(posedge CLK); #1;

    // bit_valid in IDLE must not start or complete anything
    for (int i = 0; i < 10; i++) strobe(1'b0, 0);
    chk("idle_bv_done", done_cnt, 0);
    chk("idle_bv_busy", busy, 0);

    for (int v = 0; v < 15; v++) begin
      send_frame(vecs[v].data, vecs[v].pe, vecs[v].typ, vecs[v].pb, vecs[v].sb, vecs[v].gap, 1'b0);
      chk($sformatf("v%0d_frame_done", v), frame_done, 1);
      chk($sformatf("v%0d_p_data", v), P_DATA, vecs[v].exp_data);
      chk($sformatf("v%0d_par_err", v), par_err, vecs[v].exp_par);
      chk($sformatf("v%0d_stp_err", v), stp_err, vecs[v].exp_stp);
      chk($sformatf("v%0d_busy_low", v), busy, 0);
      err_clr = vecs[v].clr;
      @(posedge CLK); #1;
      err_clr = 1'b0;
      chk($sformatf("v%0d_done_pulse", v), frame_done, 0);
      chk($sformatf("v%0d_par_cnt", v), par_err_cnt, cnt_exp(vecs[v].exp_pc));
      chk($sformatf("v%0d_stp_cnt", v), stp_err_cnt, cnt_exp(vecs[v].exp_sc));
      chk($sformatf("v%0d_hold_data", v), P_DATA, vecs[v].exp_data);
    end
    chk("table_done_count", done_cnt, 15);

    // frame_start and bit_valid together: the bit must be dropped
    send_frame(8'h00, 1'b0, 2'd0, 1'b0, 1'b1, 1, 1'b1);
    chk("sim_start_done", frame_done, 1);
    chk("sim_start_data", P_DATA, 8'h00);
    chk("sim_start_par", par_err, 0);
    @(posedge CLK); #1;

    // abort after 4 data bits, then a full 0x3C frame
    begin
      int d0;
      d0 = done_cnt;
      frame_start = 1'b1; PAR_EN = 1'b1; PAR_TYP = 2'd2;
      @(posedge CLK); #1;
      frame_start = 1'b0;
      for (int i = 0; i < 4; i++) strobe(1'b1, 1);
      send_frame(8'h3C, 1'b0, 2'd0, 1'b0, 1'b1, 1, 1'b0);
      chk("abort_frame_done", frame_done, 1);
      chk("abort_p_data", P_DATA, 8'h3C);
      chk("abort_par", par_err, 0);
      @(posedge CLK); #1;
      chk("abort_one_done", done_cnt - d0, 1);
    end

    // parity-error frame to leave nonzero outputs, then reset mid-frame
    send_frame(8'hC3, 1'b1, 2'd0, 1'b1, 1'b0, 1, 1'b0);
    @(posedge CLK); #1;
    begin
      int d1;
      frame_start = 1'b1; PAR_EN = 1'b0;
      @(posedge CLK); #1;
      frame_start = 1'b0;
      for (int i = 0; i < 3; i++) strobe(1'b1, 1);
      RST = 1'b0;
      @(posedge CLK); #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_p_data", P_DATA, 0);
      chk("mid_rst_par_err", par_err, 0);
      chk("mid_rst_stp_err", stp_err, 0);
      chk("mid_rst_done", frame_done, 0);
      chk("mid_rst_par_cnt", par_err_cnt, 0);
      chk("mid_rst_stp_cnt", stp_err_cnt, 0);
      RST = 1'b1;
      d1 = done_cnt;
      for (int i = 0; i < 9; i++) strobe(1'b1, 1);
      @(posedge CLK); #1;
      chk("post_rst_no_done", done_cnt - d1, 0);
      chk("post_rst_busy", busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_frame_checker.md
# rx_frame_checker

Parametrised receive-side frame checker for the UART RX path. Consumes the bit-strobed sampled line after start-bit detection, deserialises DATA_WIDTH data bits LSB first, and checks the parity bit in one of four modes and the stop bit. Presents the received word with parity and framing error flags, and keeps saturating error counters. Sits between the RX sampler/start-check and the RX output register, and replaces the standalone combinational parity check.

## Interface
- DATA_WIDTH, 8: data bits per frame; legal range 5..9.
- CNT_WIDTH, 8: width of each error counter.

- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-low reset.
- frame_start  in  1  one-cycle pulse when a valid start bit has been detected.
- bit_valid  in  1  one-cycle strobe; sampled_bit is valid at the mid-bit point.
- sampled_bit  in  1  majority-sampled RX line value.
- PAR_EN  in  1  parity bit present in frame.
- PAR_TYP  in  2  00 even, 01 odd, 10 mark (expect 1), 11 space (expect 0).
- err_clr  in  1  synchronous clear of both error counters.
- P_DATA  out  DATA_WIDTH  last received word.
- frame_done  out  1  one-cycle pulse when a frame completes.
- par_err  out  1  parity error of last frame.
- stp_err  out  1  stop-bit (framing) error of last frame.
- busy  out  1  high when state is not IDLE.
- par_err_cnt  out  CNT_WIDTH  saturating parity-error count.
- stp_err_cnt  out  CNT_WIDTH  saturating framing-error count.

## Operation
- States: IDLE, DATA, PARITY, STOP.
- IDLE: frame_start samples PAR_EN and PAR_TYP into internal config, clears shift register, bit counter and parity accumulator, then moves to DATA. The config is stable for the whole frame.
- DATA: each bit_valid shifts sampled_bit in at the MSB side, so bit 0 lands at P_DATA[0], and XORs it into the accumulator. The strobe that carries data bit DATA_WIDTH-1 moves to PARITY if parity is enabled, otherwise to STOP.
- PARITY: on bit_valid, the expected bit is as follows. Even = XOR of the data; odd = XNOR of the data; mark = 1; space = 0. A mismatch latches the internal parity flag. Then moves to STOP.
- STOP: on bit_valid, stp flag = ~sampled_bit, and the machine returns to IDLE. On the same edge, P_DATA, par_err and stp_err update and frame_done asserts for that one cycle.
- par_err is 0 for frames without parity.
- P_DATA, par_err and stp_err hold their values until the next frame_done.
- frame_start while busy aborts the current frame without frame_done or counter update and restarts at DATA with freshly sampled config.
- bit_valid in IDLE is ignored. bit_valid and frame_start in the same cycle: frame_start wins and the bit is ignored.
- Counters increment by 1 on a frame_done with the matching error and saturate at all-ones.
- err_clr clears both counters; err_clr and an increment in the same cycle give 0.

## Timing
- Reset (RST=0 at a clock edge) values:
  - state IDLE.
  - P_DATA 0.
  - frame_done 0, par_err 0, stp_err 0, busy 0.
  - Both counters 0.
- Reset mid-frame discards the frame.
- busy rises the cycle after frame_start and falls the cycle after the stop-bit strobe.
- frame_done is registered. It is high in the cycle after the stop-bit bit_valid, with the outputs valid in that same cycle.
- Counters reflect a frame the cycle after frame_done.
- Minimum spacing between bit_valid strobes is 1 cycle. The block accepts back-to-back strobes.

## Configuration
- RX_ERR_CNT_EN defined: counters and err_clr logic are compiled in as described above.
- RX_ERR_CNT_EN undefined: counter registers are removed, par_err_cnt and stp_err_cnt are tied to 0, and err_clr is ignored. All other behaviour is identical.

## Test plan
- DATA_WIDTH=8, PAR_EN=0: frame with data 0xA5 and stop 1 → one frame_done with P_DATA=0xA5, par_err=0, stp_err=0, counters unchanged.
- PAR_EN=1, PAR_TYP=00, data 0x03:
  - Parity bit 0 → par_err=0.
  - Repeat with parity bit 1 → par_err=1 and par_err_cnt=1.
- PAR_TYP=01 with data 0x07 and parity bit 0 → par_err=0. PAR_TYP=10 with parity bit 0 → par_err=1. PAR_TYP=11 with parity bit 0 → par_err=0.
- Stop bit 0 on data 0xFF → stp_err=1 and stp_err_cnt=1. Assert err_clr in the same cycle as the next erroneous frame_done → counter reads 0.
- frame_start after 4 data bits, then a full frame of 0x3C → exactly one frame_done with P_DATA=0x3C. Also: RST low mid-frame → all outputs 0 and state IDLE.
- CNT_WIDTH=2 with five parity-error frames → par_err_cnt saturates at 3. Rerun without RX_ERR_CNT_EN → counters read 0.
